// File: rtl/vga_timing_gen.sv
// Raster timing generator: column/row counters with sync, data-enable and line/frame markers.
// Define VGA_TIMING_REG_OUT_EN to register every output (one extra clock of latency).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CNT_W    = 10
) (
  input  logic             CLK,
  input  logic             i_Reset,
  input  logic             i_Enable,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_DE,
  output logic [CNT_W-1:0] o_CountCol,
  output logic [CNT_W-1:0] o_CountRow,
  output logic             o_LineEnd,
  output logic             o_FrameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             H_ASSERT = 1'(H_POL);
  localparam logic             V_ASSERT = 1'(V_POL);

  // Stage p0: free-running raster counters and their combinational decode
  logic [CNT_W-1:0] col_p0, row_p0;
  logic             hsync_p0, vsync_p0, de_p0, line_end_p0, frame_start_p0;

  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (i_Enable) begin
      if (col_p0 != H_LAST) begin
        col_p0 <= col_p0 + 1'b1;
      end else begin
        col_p0 <= '0;
        row_p0 <= (row_p0 != V_LAST) ? row_p0 + 1'b1 : '0;
      end
    end
  end

  always_comb begin
    hsync_p0       = ((col_p0 >= HS_FIRST) && (col_p0 <= HS_LAST)) ? H_ASSERT : ~H_ASSERT;
    vsync_p0       = ((row_p0 >= VS_FIRST) && (row_p0 <= VS_LAST)) ? V_ASSERT : ~V_ASSERT;
    de_p0          = (col_p0 < H_ACT) && (row_p0 < V_ACT);
    line_end_p0    = (col_p0 == H_LAST);
    frame_start_p0 = (col_p0 == '0) && (row_p0 == '0);
  end

`ifdef VGA_TIMING_REG_OUT_EN
  // Stage p1: output registers, all outputs mutually aligned one clock behind p0
  logic [CNT_W-1:0] col_p1, row_p1;
  logic             hsync_p1, vsync_p1, de_p1, line_end_p1, frame_start_p1;

  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      col_p1         <= '0;
      row_p1         <= '0;
      hsync_p1       <= ~H_ASSERT;
      vsync_p1       <= ~V_ASSERT;
      de_p1          <= 1'b0;
      line_end_p1    <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else if (i_Enable) begin
      col_p1         <= col_p0;
      row_p1         <= row_p0;
      hsync_p1       <= hsync_p0;
      vsync_p1       <= vsync_p0;
      de_p1          <= de_p0;
      line_end_p1    <= line_end_p0;
      frame_start_p1 <= frame_start_p0;
    end
  end

  assign o_CountCol   = col_p1;
  assign o_CountRow   = row_p1;
  assign o_HSync      = hsync_p1;
  assign o_VSync      = vsync_p1;
  assign o_DE         = de_p1;
  assign o_LineEnd    = line_end_p1;
  assign o_FrameStart = frame_start_p1;
`else
  assign o_CountCol   = col_p0;
  assign o_CountRow   = row_p0;
  assign o_HSync      = hsync_p0;
  assign o_VSync      = vsync_p0;
  assign o_DE         = de_p0;
  assign o_LineEnd    = line_end_p0;
  assign o_FrameStart = frame_start_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, small inverted-polarity and zero-porch instances
// checked against a linear-pixel-index reference model, plus a vector table.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk, rst, en;
  logic hs0, vs0, de0, le0, fs0; logic [9:0] col0, row0;
  logic hs1, vs1, de1, le1, fs1; logic [3:0] col1, row1;
  logic hs2, vs2, de2, le2, fs2; logic [2:0] col2, row2;

  vga_timing_gen dut0 (
    .CLK(clk), .i_Reset(rst), .i_Enable(en), .o_HSync(hs0), .o_VSync(vs0), .o_DE(de0),
    .o_CountCol(col0), .o_CountRow(row0), .o_LineEnd(le0), .o_FrameStart(fs0));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .CNT_W(4)
  ) dut1 (
    .CLK(clk), .i_Reset(rst), .i_Enable(en), .o_HSync(hs1), .o_VSync(vs1), .o_DE(de1),
    .o_CountCol(col1), .o_CountRow(row1), .o_LineEnd(le1), .o_FrameStart(fs1));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(0), .H_SYNC(2), .H_BP(0), .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(0),
    .H_POL(0), .V_POL(0), .CNT_W(3)
  ) dut2 (
    .CLK(clk), .i_Reset(rst), .i_Enable(en), .o_HSync(hs2), .o_VSync(vs2), .o_DE(de2),
    .o_CountCol(col2), .o_CountRow(row2), .o_LineEnd(le2), .o_FrameStart(fs2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int ha, hfp, hs, hbp, va, vfp, vs, vbp; bit hpol, vpol; } timing_t;
  typedef struct { logic hs, vs, de, le, fs; logic [31:0] col, row; } out_t;
  typedef struct { bit en; int n; logic [3:0] col, row; logic hs, vs, de, le, fs; } vec_t;

  timing_t tm[3];
  int      pos[3];
  out_t    rg[3];
  int      checks = 0;
  int      errors = 0;

  function automatic int h_total(timing_t t);
    return t.ha + t.hfp + t.hs + t.hbp;
  endfunction

  function automatic int frame_total(timing_t t);
    return h_total(t) * (t.va + t.vfp + t.vs + t.vbp);
  endfunction

  // Raster position is a single pixel index; column/row fall out of div/mod.
  function automatic out_t decode(timing_t t, int p);
    out_t e;
    int ht, c, r, hstart, vstart;
    ht = h_total(t);
    c = p % ht;
    r = p / ht;
    hstart = t.ha + t.hfp;
    vstart = t.va + t.vfp;
    e.col = c;
    e.row = r;
    e.hs  = (c >= hstart && c < hstart + t.hs) ? t.hpol : !t.hpol;
    e.vs  = (r >= vstart && r < vstart + t.vs) ? t.vpol : !t.vpol;
    e.de  = (c < t.ha) && (r < t.va);
    e.le  = (c == ht - 1);
    e.fs  = (p == 0);
    return e;
  endfunction

  function automatic out_t expected(int k);
`ifdef VGA_TIMING_REG_OUT_EN
    return rg[k];
`else
    return decode(tm[k], pos[k]);
`endif
  endfunction

  function automatic out_t get_act(int k);
    out_t a;
    case (k)
      0: begin a.hs = hs0; a.vs = vs0; a.de = de0; a.le = le0; a.fs = fs0; a.col = 32'(col0); a.row = 32'(row0); end
      1: begin a.hs = hs1; a.vs = vs1; a.de = de1; a.le = le1; a.fs = fs1; a.col = 32'(col1); a.row = 32'(row1); end
      default: begin a.hs = hs2; a.vs = vs2; a.de = de2; a.le = le2; a.fs = fs2; a.col = 32'(col2); a.row = 32'(row2); end
    endcase
    return a;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pos[k] = 0;
      rg[k].hs = !tm[k].hpol; rg[k].vs = !tm[k].vpol;
      rg[k].de = 1'b0; rg[k].le = 1'b0; rg[k].fs = 1'b0;
      rg[k].col = 0; rg[k].row = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      rg[k]  = decode(tm[k], pos[k]);
      pos[k] = (pos[k] + 1) % frame_total(tm[k]);
    end
  endtask

  task automatic cmp(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    out_t a, e;
    for (int k = 0; k < 3; k++) begin
      a = get_act(k);
      e = expected(k);
      cmp($sformatf("%s dut%0d col", tag, k), a.col, e.col);
      cmp($sformatf("%s dut%0d row", tag, k), a.row, e.row);
      cmp($sformatf("%s dut%0d hsync", tag, k), 32'(a.hs), 32'(e.hs));
      cmp($sformatf("%s dut%0d vsync", tag, k), 32'(a.vs), 32'(e.vs));
      cmp($sformatf("%s dut%0d de", tag, k), 32'(a.de), 32'(e.de));
      cmp($sformatf("%s dut%0d line_end", tag, k), 32'(a.le), 32'(e.le));
      cmp($sformatf("%s dut%0d frame_start", tag, k), 32'(a.fs), 32'(e.fs));
    end
  endtask

  task automatic tick(bit e, string tag);
    en = e;
    @(posedge clk);
    if (rst) model_reset();
    else if (e) model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset lands between clock edges; outputs must change before any edge arrives.
  task automatic async_reset(string tag);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, " async"});
    tick(1'b1, {tag, " held"});
    rst = 1'b0;
    tick(1'b1, {tag, " resume"});
  endtask

  vec_t vt[12];

  initial begin
    int hs_low, de_cnt, le_a, le_b, fs_a, fs_b, seen;
    logic [9:0] col_hold;
    logic       hs_hold;

    tm[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    tm[1] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1};
    tm[2] = '{4, 0, 2, 0, 2, 0, 1, 0, 1'b0, 1'b0};

    // {en, cycles, col, row, hsync, vsync, de, line_end, frame_start} for dut1
    vt[0]  = '{1'b1, 0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 10, 4'd10, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 5,  4'd10, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1,  4'd11, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1,  4'd12, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1,  4'd13, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1,  4'd0,  4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 56, 4'd0,  4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 13, 4'd13, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1,  4'd0,  4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 13, 4'd13, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b1, 1,  4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    en  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

`ifndef VGA_TIMING_REG_OUT_EN
    for (int i = 0; i < 12; i++) begin
      repeat (vt[i].n) tick(vt[i].en, "table run");
      cmp($sformatf("vec%0d col", i), 32'(col1), 32'(vt[i].col));
      cmp($sformatf("vec%0d row", i), 32'(row1), 32'(vt[i].row));
      cmp($sformatf("vec%0d hsync", i), 32'(hs1), 32'(vt[i].hs));
      cmp($sformatf("vec%0d vsync", i), 32'(vs1), 32'(vt[i].vs));
      cmp($sformatf("vec%0d de", i), 32'(de1), 32'(vt[i].de));
      cmp($sformatf("vec%0d line_end", i), 32'(le1), 32'(vt[i].le));
      cmp($sformatf("vec%0d frame_start", i), 32'(fs1), 32'(vt[i].fs));
    end
`endif

    // Line/frame periods and pulse widths
    async_reset("line");
    hs_low = 0; de_cnt = 0; le_a = -1; le_b = -1; fs_a = -1; fs_b = -1;
    for (int i = 2; i <= 1601; i++) begin
      tick(1'b1, "line");
      if (i <= 801 && hs0 == 1'b0) hs_low++;
      if (i <= 99 && de1 == 1'b1) de_cnt++;
      if (le0) begin if (le_a < 0) le_a = i; else if (le_b < 0) le_b = i; end
      if (fs1) begin if (fs_a < 0) fs_a = i; else if (fs_b < 0) fs_b = i; end
    end
    cmp("hsync low width", 32'(hs_low), 32'd96);
    cmp("line period", 32'(le_b - le_a), 32'd800);
    cmp("small frame period", 32'(fs_b - fs_a), 32'd98);
    cmp("small de count", 32'(de_cnt), 32'd32);

    // Enable dropped just before the sync pulse
    async_reset("freeze");
    repeat (654) tick(1'b1, "to655");
    col_hold = col0;
    hs_hold  = hs0;
    repeat (37) tick(1'b0, "frozen");
    cmp("frozen col", 32'(col0), 32'(col_hold));
    cmp("frozen hsync", 32'(hs0), 32'(hs_hold));
    seen = 0;
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, "reenable");
      if (seen == 0 && hs0 == 1'b0) seen = i;
    end
    cmp("hsync edges after re-enable", 32'(seen), 32'(1 + LAT));

    // Mid-line asynchronous reset
    repeat (300) tick(1'b1, "midline");
    async_reset("midline reset");

    // Randomized enable with occasional async reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset("rand reset");
      else tick($urandom_range(0, 3) != 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
